// File: rtl/riscv_mon_pkg.sv
// Shared definitions for the retire-stream run monitor.
// State encoding, halt opcode and state helpers.
package riscv_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    localparam logic [31:0] JAL_SELF = 32'h0000_006F;

    function automatic logic is_live(input mon_state_e s);
        return (s == ST_IDLE) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/mon_log_fifo.sv
// Synchronous show-ahead FIFO for the monitor's store log.
// A push into a full FIFO succeeds only when a pop frees a slot that cycle.
module mon_log_fifo
    import riscv_mon_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire-stream run monitor: shadow registers, run counters,
// halt/timeout detection and a drainable store log.
module riscv_retire_monitor
    import riscv_mon_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int NUM_WATCH   = 7,
    parameter int WATCH_BASE  = 0,
    parameter int HALT_REPEAT = 3,
    parameter int MAX_CYCLES  = 1000,
    parameter int LOG_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      retire_valid,
    input  logic [XLEN-1:0]           pc,
    input  logic [31:0]               instruction,
    input  logic                      reg_write,
    input  logic [4:0]                rd,
    input  logic [XLEN-1:0]           rd_data,
    input  logic                      mem_write,
    input  logic [XLEN-1:0]           mem_addr,
    input  logic [XLEN-1:0]           mem_data,
    output logic [NUM_WATCH*XLEN-1:0] watch_vals,
    output logic [31:0]               cycle_count,
    output logic [31:0]               instr_count,
    output logic [1:0]                state,
    output logic                      halted,
    output logic                      timed_out,
    output logic                      log_valid,
    input  logic                      log_ready,
    output logic [XLEN-1:0]           log_addr,
    output logic [XLEN-1:0]           log_data,
    output logic                      log_overflow
);

    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam int LW = 2 * XLEN;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } log_entry_t;

    mon_state_e      state_q, state_d;
    logic [31:0]     cycle_q, instr_q;
    logic [RW-1:0]   rep_q, rep_d;
    logic [XLEN-1:0] prev_pc_q;
    logic            have_prev_q;
    logic            ovf_q;
    logic [XLEN-1:0] shadow_q [NUM_WATCH];

    logic            live, accept, pc_match;
    logic            halt_hit, timeout_hit;
    logic            push, pop, drop, log_full, log_empty;
    logic [$clog2(LOG_DEPTH):0] log_count;
    log_entry_t      push_e, head_e;

    assign live        = is_live(state_q);
    assign accept      = retire_valid && live;
    assign pc_match    = have_prev_q && (pc == prev_pc_q);
    assign rep_d       = pc_match ? rep_q + RW'(1) : '0;
    assign timeout_hit = live && (cycle_q == 32'(MAX_CYCLES - 1));
    assign halt_hit    = accept &&
                         ((pc_match && rep_d >= RW'(HALT_REPEAT - 1)) ||
                          instruction == JAL_SELF);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept)
                    state_d = ST_RUN;
                // A halt outranks a timeout landing on the same edge
                if (halt_hit)
                    state_d = ST_HALTED;
                else if (timeout_hit)
                    state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cycle_q     <= '0;
            instr_q     <= '0;
            rep_q       <= '0;
            prev_pc_q   <= '0;
            have_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter holds at MAX_CYCLES-1 as the run times out
            if (live && !timeout_hit)
                cycle_q <= cycle_q + 32'd1;
            if (accept) begin
                instr_q     <= instr_q + 32'd1;
                rep_q       <= rep_d;
                prev_pc_q   <= pc;
                have_prev_q <= 1'b1;
            end
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WATCH; i++)
                shadow_q[i] <= '0;
        end else if (accept && reg_write && rd != 5'd0) begin
            for (int i = 0; i < NUM_WATCH; i++)
                if (rd == 5'(WATCH_BASE + i))
                    shadow_q[i] <= rd_data;
        end
    end

    for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
        assign watch_vals[g*XLEN +: XLEN] = shadow_q[g];
    end

    assign log_empty = (log_count == '0);
    assign pop       = log_ready && !log_empty;
    assign push      = accept && mem_write;
    assign drop      = push && log_full && !pop;
    assign push_e    = '{addr: mem_addr, data: mem_data};

    mon_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LW)
    ) u_log (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_e),
        .full      (log_full),
        .pop       (pop),
        .valid     (log_valid),
        .head      (head_e),
        .count     (log_count)
    );

    assign log_addr     = head_e.addr;
    assign log_data     = head_e.data;
    assign log_overflow = ovf_q;
    assign cycle_count  = cycle_q;
    assign instr_count  = instr_q;
    assign state        = state_q;
    assign halted       = (state_q == ST_HALTED);
    assign timed_out    = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Randomised and directed bench for riscv_retire_monitor,
// checked against a queue-based run model.
module tb_riscv_retire_monitor;

    localparam int XLEN  = 32;
    localparam int NW    = 7;
    localparam int BASE  = 0;
    localparam int HR    = 3;
    localparam int MAXC  = 60;
    localparam int DEPTH = 4;
    localparam logic [31:0] JAL = 32'h0000_006F;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              retire_valid;
    logic [XLEN-1:0]   pc;
    logic [31:0]       instruction;
    logic              reg_write;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd_data;
    logic              mem_write;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_data;
    logic [NW*XLEN-1:0] watch_vals;
    logic [31:0]       cycle_count;
    logic [31:0]       instr_count;
    logic [1:0]        state;
    logic              halted;
    logic              timed_out;
    logic              log_valid;
    logic              log_ready;
    logic [XLEN-1:0]   log_addr;
    logic [XLEN-1:0]   log_data;
    logic              log_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    logic [1:0]        m_state;
    logic [31:0]       m_cyc, m_instr;
    logic [XLEN-1:0]   m_shadow [NW];
    logic [2*XLEN-1:0] m_q [$];
    logic              m_ovf;
    logic [XLEN-1:0]   m_prev;
    bit                m_have_prev;
    int                m_rep;

    riscv_retire_monitor #(
        .XLEN(XLEN), .NUM_WATCH(NW), .WATCH_BASE(BASE),
        .HALT_REPEAT(HR), .MAX_CYCLES(MAXC), .LOG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .retire_valid(retire_valid),
        .pc(pc), .instruction(instruction), .reg_write(reg_write),
        .rd(rd), .rd_data(rd_data), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .watch_vals(watch_vals), .cycle_count(cycle_count),
        .instr_count(instr_count), .state(state), .halted(halted),
        .timed_out(timed_out), .log_valid(log_valid),
        .log_ready(log_ready), .log_addr(log_addr),
        .log_data(log_data), .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit live, halt, tout, match;
        if (reset) begin
            m_state = 2'd0; m_cyc = 0; m_instr = 0; m_ovf = 1'b0;
            m_prev = 0; m_have_prev = 0; m_rep = 0;
            foreach (m_shadow[i]) m_shadow[i] = 0;
            m_q.delete();
            return;
        end
        live = (m_state == 2'd0) || (m_state == 2'd1);
        halt = 0;
        tout = 0;
        if (log_ready && m_q.size() > 0)
            void'(m_q.pop_front());
        if (retire_valid && live) begin
            if (m_state == 2'd0) m_state = 2'd1;
            m_instr++;
            if (reg_write && rd != 0 && int'(rd) >= BASE && int'(rd) < BASE + NW)
                m_shadow[int'(rd) - BASE] = rd_data;
            match = m_have_prev && (pc == m_prev);
            m_rep = match ? m_rep + 1 : 0;
            m_prev = pc;
            m_have_prev = 1;
            if ((match && m_rep >= HR - 1) || instruction == JAL) halt = 1;
            if (mem_write) begin
                if (m_q.size() < DEPTH) m_q.push_back({mem_addr, mem_data});
                else m_ovf = 1'b1;
            end
        end
        if (live) begin
            if (m_cyc == 32'(MAXC - 1)) tout = 1;
            else m_cyc++;
        end
        if (halt) m_state = 2'd2;
        else if (tout) m_state = 2'd3;
    endtask

    task automatic compare_all();
        logic [NW*XLEN-1:0] exp_w;
        logic [2*XLEN-1:0]  hd;
        for (int i = 0; i < NW; i++) exp_w[i*XLEN +: XLEN] = m_shadow[i];
        hd = (m_q.size() > 0) ? m_q[0] : '0;
        check("state", 256'(state), 256'(m_state));
        check("halted", 256'(halted), 256'(m_state == 2'd2));
        check("timed_out", 256'(timed_out), 256'(m_state == 2'd3));
        check("cycle_count", 256'(cycle_count), 256'(m_cyc));
        check("instr_count", 256'(instr_count), 256'(m_instr));
        check("watch_vals", 256'(watch_vals), 256'(exp_w));
        check("log_valid", 256'(log_valid), 256'(m_q.size() > 0));
        check("log_addr", 256'(log_addr), 256'(hd[2*XLEN-1:XLEN]));
        check("log_data", 256'(log_data), 256'(hd[XLEN-1:0]));
        check("log_overflow", 256'(log_overflow), 256'(m_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        reset = 0; retire_valid = 0; pc = 0; instruction = NOP;
        reg_write = 0; rd = 0; rd_data = 0; mem_write = 0;
        mem_addr = 0; mem_data = 0; log_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic retire(input logic [31:0] p, input logic [31:0] ins,
                          input logic rw, input logic [4:0] r,
                          input logic [31:0] rdd, input logic mw,
                          input logic [31:0] ma, input logic [31:0] md,
                          input logic rdy);
        retire_valid = 1; pc = p; instruction = ins; reg_write = rw;
        rd = r; rd_data = rdd; mem_write = mw; mem_addr = ma;
        mem_data = md; log_ready = rdy;
        tick();
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("reset_state", 256'(state), 256'(0));

        // ADDI x1..x5 = 10..50, then a write to x0
        for (int k = 1; k <= 5; k++)
            retire(32'(4*(k-1)), {12'(10*k), 5'd0, 3'b000, 5'(k), 7'h13},
                   1, 5'(k), 32'(10*k), 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            check("addi_slot", 256'(watch_vals[k*XLEN +: XLEN]), 256'(10*k));
        check("addi_instr", 256'(instr_count), 256'(5));
        retire(32'd20, NOP, 1, 5'd0, 32'd99, 0, 0, 0, 0);
        check("x0_slot", 256'(watch_vals[0 +: XLEN]), 256'(0));

        // Self-loop halt on PC 0,4,8,8,8
        do_reset();
        retire(0, NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(4, NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(8, NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(8, NOP, 0, 0, 0, 0, 0, 0, 0);
        check("not_yet_halted", 256'(halted), 256'(0));
        retire(8, NOP, 0, 0, 0, 0, 0, 0, 0);
        check("loop_halted", 256'(halted), 256'(1));
        for (int k = 0; k < 3; k++)
            retire(32'(100 + 4*k), NOP, 1, 5'd2, 32'd7, 0, 0, 0, 0);
        check("frozen_instr", 256'(instr_count), 256'(5));
        check("frozen_cycle", 256'(cycle_count), 256'(5));

        // jal x0,0 halts at once with its writeback applied
        do_reset();
        retire(0, NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(4, NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(8, JAL, 1, 5'd3, 32'd77, 0, 0, 0, 0);
        check("jal_state", 256'(state), 256'(2));
        check("jal_wb", 256'(watch_vals[3*XLEN +: XLEN]), 256'(77));

        // Timeout with distinct PCs
        do_reset();
        for (int k = 0; k < MAXC - 1; k++)
            retire(32'(4*k), NOP, 0, 0, 0, 0, 0, 0, 0);
        check("pre_timeout", 256'(timed_out), 256'(0));
        retire(32'h1000, NOP, 0, 0, 0, 0, 0, 0, 0);
        check("timed_out", 256'(timed_out), 256'(1));
        check("timeout_cycle", 256'(cycle_count), 256'(MAXC - 1));

        // Halt and timeout on the same edge
        do_reset();
        for (int k = 0; k < MAXC - 1; k++)
            retire(32'(4*k), NOP, 0, 0, 0, 0, 0, 0, 0);
        retire(32'h1000, JAL, 0, 0, 0, 0, 0, 0, 0);
        check("halt_wins", 256'(state), 256'(2));

        // Store log overflow then drain
        do_reset();
        for (int k = 0; k < 6; k++)
            retire(32'(4*k), NOP, 0, 0, 0, 1, 32'(100 + k), 32'(1000 + k), 0);
        check("ovf_set", 256'(log_overflow), 256'(1));
        idle_inputs();
        log_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check("drain_addr", 256'(log_addr), 256'(100 + k));
            check("drain_data", 256'(log_data), 256'(1000 + k));
            tick();
        end
        check("drained", 256'(log_valid), 256'(0));

        // Push and pop with one entry queued
        do_reset();
        retire(0, NOP, 0, 0, 0, 1, 32'hA0, 32'hA1, 0);
        retire(4, NOP, 0, 0, 0, 1, 32'hB0, 32'hB1, 1);
        check("pp_valid", 256'(log_valid), 256'(1));
        check("pp_head", 256'(log_addr), 256'(32'hB0));

        // Reset mid-run with two entries queued
        do_reset();
        retire(0, NOP, 1, 5'd1, 32'd5, 1, 32'h10, 32'h11, 0);
        retire(4, NOP, 1, 5'd2, 32'd6, 1, 32'h20, 32'h21, 0);
        do_reset();
        check("mid_reset_state", 256'(state), 256'(0));
        check("mid_reset_log", 256'(log_valid), 256'(0));
        retire(8, NOP, 0, 0, 0, 0, 0, 0, 0);
        check("rerun", 256'(state), 256'(1));

        // Randomised runs
        for (int r = 0; r < 20; r++) begin
            do_reset();
            for (int c = 0; c < 70; c++) begin
                retire_valid = ($urandom_range(0, 3) != 0);
                pc           = 32'(4 * $urandom_range(0, 5));
                instruction  = ($urandom_range(0, 15) == 0) ? JAL : $urandom;
                reg_write    = 1'($urandom);
                rd           = 5'($urandom);
                rd_data      = $urandom;
                mem_write    = 1'($urandom);
                mem_addr     = $urandom;
                mem_data     = $urandom;
                log_ready    = ($urandom_range(0, 2) == 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
